fp_accumulator: RTL

Sequential fp16 (IEEE 754 binary16) accumulator that consumes the product stream of the 3-stage fp16 multiplier and sums it into a running total. It is the downstream dot-product reduction stage. Products enter through a valid/ready handshake, and an `in_last` flag closes a group. The rounded sum and element count are then presented on a valid/ready output port and held until taken.

---
 rtl/fp_acc_pkg.sv | 23 ++
 rtl/fp_acc_if.sv | 26 ++
 rtl/fp16_round.sv | 24 ++
 rtl/fp_accumulator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_acc_pkg.sv
// Shared types and fp16 constants for the fp16 group accumulator.
package fp_acc_pkg;

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned BIAS   = 15;
  // Hidden bit + fraction + guard/round/sticky.
  localparam int unsigned SIG_W  = FRAC_W + 4;

  localparam logic [15:0] FP16_QNAN       = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF    = 16'h7C00;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StOut
  } state_e;

endpackage

// File: rtl/fp_acc_if.sv
// Product input stream and group-sum output port of the fp16 accumulator.
interface fp_acc_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/fp16_round.sv
// Round-to-nearest-even of a normalized {sign, exp, 1.frac GRS} value into packed fp16.
module fp16_round
  import fp_acc_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [SIG_W-1:0] i_sig,
  output logic [15:0]      o_result,
  output logic             o_ovf
);

  logic          w_inc;
  logic [11:0]   w_man;
  logic [EXP_W:0] w_exp;

  assign w_inc = i_sig[2] & (i_sig[1] | i_sig[0] | i_sig[3]);
  assign w_man = {1'b0, i_sig[13:3]} + {11'd0, w_inc};
  // A carry out of the significand leaves 1.000.. and bumps the exponent.
  assign w_exp = {1'b0, i_exp} + {{EXP_W{1'b0}}, w_man[11]};

  assign o_ovf    = (w_exp >= 6'd31);
  assign o_result = {i_sign, w_exp[4:0], (w_man[11] ? w_man[10:1] : w_man[9:0])};

endmodule

// File: rtl/fp_accumulator.sv
// Sequential fp16 group accumulator: align, add, normalize, round per product.
// FP_ACC_SATURATE_EN: finite overflow returns signed max-finite instead of Inf.
module fp_accumulator
  import fp_acc_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  fp_acc_if.slave bus
);

  state_e           r_state, w_state_d;
  logic [N-1:0]     r_acc, r_op, r_spec_val;
  logic             r_last, r_sign, r_sub, r_special, r_zero;
  logic [CNT_W-1:0] r_count;
  logic [EXP_W-1:0] r_exp;
  logic [SIG_W-1:0] r_sig_big, r_sig_small;
  logic [SIG_W:0]   r_sum;

  // Alignment of accumulator (a) against the latched product (b).
  logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
  logic [10:0]      w_man_a, w_man_b, w_man_big, w_man_small;
  logic             w_a_big, w_sign_big;
  logic [SIG_W-1:0] w_ext, w_mask, w_shifted;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special;
  logic [N-1:0]     w_spec_val;

  assign w_exp_a = r_acc[14:10];
  assign w_exp_b = r_op[14:10];
  assign w_man_a = (w_exp_a != '0) ? {1'b1, r_acc[9:0]} : 11'd0;
  assign w_man_b = (w_exp_b != '0) ? {1'b1, r_op[9:0]} : 11'd0;
  assign w_a_big = ({w_exp_a, w_man_a} >= {w_exp_b, w_man_b});

  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
  assign w_man_big   = w_a_big ? w_man_a : w_man_b;
  assign w_man_small = w_a_big ? w_man_b : w_man_a;
  assign w_sign_big  = w_a_big ? r_acc[15] : r_op[15];
  assign w_diff      = w_exp_big - w_exp_small;
  assign w_ext       = {w_man_small, 3'b000};

  always_comb begin
    w_mask    = '0;
    w_shifted = '0;
    if (w_diff > 5'd13) begin
      w_shifted = {13'd0, |w_man_small};
    end else begin
      w_shifted    = w_ext >> w_diff;
      w_mask       = (14'd1 << w_diff) - 14'd1;
      w_shifted[0] = w_shifted[0] | (|(w_ext & w_mask));
    end
  end

  assign w_a_nan   = (w_exp_a == 5'h1f) && (r_acc[9:0] != '0);
  assign w_b_nan   = (w_exp_b == 5'h1f) && (r_op[9:0] != '0);
  assign w_a_inf   = (w_exp_a == 5'h1f) && (r_acc[9:0] == '0);
  assign w_b_inf   = (w_exp_b == 5'h1f) && (r_op[9:0] == '0);
  assign w_special = (w_exp_a == 5'h1f) || (w_exp_b == 5'h1f);

  always_comb begin
    w_spec_val = {r_op[15], FP16_POS_INF[14:0]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_acc[15] != r_op[15]))) begin
      w_spec_val = FP16_QNAN;
    end else if (w_a_inf) begin
      w_spec_val = {r_acc[15], FP16_POS_INF[14:0]};
    end
  end

  // Normalization step helpers.
  logic [SIG_W:0]   w_sum_shl;
  logic [EXP_W-1:0] w_exp_dec;
  logic             w_norm_done;

  assign w_sum_shl   = r_sum << 1;
  assign w_exp_dec   = r_exp - 5'd1;
  assign w_norm_done = r_special || (r_sum == '0) || r_sum[14] || r_sum[13] ||
                       w_sum_shl[13] || (w_exp_dec == '0);

  // Rounding and overflow mapping.
  logic [N-1:0] w_rnd_data, w_ovf_val, w_result;
  logic         w_rnd_ovf;

  fp16_round u_round (
    .i_sign   (r_zero ? 1'b0 : r_sign),
    .i_exp    (r_zero ? 5'd0 : r_exp),
    .i_sig    (r_zero ? 14'd0 : r_sum[13:0]),
    .o_result (w_rnd_data),
    .o_ovf    (w_rnd_ovf)
  );

`ifdef FP_ACC_SATURATE_EN
  assign w_ovf_val = {r_sign, FP16_MAX_FINITE[14:0]};
`else
  assign w_ovf_val = {r_sign, FP16_POS_INF[14:0]};
`endif

  assign w_result = r_special ? r_spec_val : (w_rnd_ovf ? w_ovf_val : w_rnd_data);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.in_valid) w_state_d = StAlign;
      StAlign: w_state_d = StAdd;
      StAdd:   w_state_d = StNorm;
      StNorm:  if (w_norm_done) w_state_d = StRound;
      StRound: w_state_d = r_last ? StOut : StIdle;
      StOut:   if (bus.out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_op        <= '0;
      r_last      <= 1'b0;
      r_count     <= '0;
      r_exp       <= '0;
      r_sig_big   <= '0;
      r_sig_small <= '0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_sum       <= '0;
      r_special   <= 1'b0;
      r_spec_val  <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_op    <= bus.in_data;
            r_last  <= bus.in_last;
            r_count <= r_count + CNT_W'(1);
          end
        end
        StAlign: begin
          r_exp       <= w_exp_big;
          r_sig_big   <= {w_man_big, 3'b000};
          r_sig_small <= w_shifted;
          r_sign      <= w_sign_big;
          r_sub       <= r_acc[15] ^ r_op[15];
          r_special   <= w_special;
          r_spec_val  <= w_spec_val;
          r_zero      <= 1'b0;
        end
        StAdd: begin
          r_sum <= r_sub ? ({1'b0, r_sig_big} - {1'b0, r_sig_small})
                         : ({1'b0, r_sig_big} + {1'b0, r_sig_small});
        end
        StNorm: begin
          if (!r_special) begin
            if (r_sum == '0) begin
              r_zero <= 1'b1;
            end else if (r_sum[14]) begin
              r_sum <= {1'b0, r_sum[14:2], r_sum[1] | r_sum[0]};
              r_exp <= r_exp + 5'd1;
            end else if (!r_sum[13]) begin
              r_sum <= w_sum_shl;
              r_exp <= w_exp_dec;
              if (w_exp_dec == '0) r_zero <= 1'b1;
            end
          end
        end
        StRound: r_acc <= w_result;
        StOut: begin
          if (bus.out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle) && !rst;
  assign bus.out_valid = (r_state == StOut);
  assign bus.out_data  = r_acc;
  assign bus.out_count = r_count;

endmodule
